// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed common-anode scan driver for a BCD-to-7-segment decoder.
// Each digit slot starts with an anti-ghosting blank interval and then drives
// the slot's anode. Leading zeros can be suppressed. New digits are captured
// into a pending register and committed only at frame boundaries, so a frame
// never shows a mix of old and new digits.
module seven_seg_scan_driver #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000,
    parameter int LZ_BLANK     = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          enable,
    input  logic                          load,
    input  logic [4*NUM_DIGITS-1:0]       digits_in,
    input  logic [NUM_DIGITS-1:0]         dp_in,
    output logic [3:0]                    bcd_out,
    output logic [NUM_DIGITS-1:0]         an_n,
    output logic                          dp_n,
    output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
    output logic                          frame_tick
);

    localparam int IW = $clog2(NUM_DIGITS);
    localparam int CW = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] CNT_DRIVE = CW'(BLANK_CYCLES);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {
        IDLE,
        BLANK,
        DRIVE
    } state_t;

    state_t                  state, state_nx;
    logic [CW-1:0]           cnt, cnt_nx;
    logic [IW-1:0]           idx_nx;
    logic                    tick_nx;

    logic [4*NUM_DIGITS-1:0] disp_digits, disp_digits_nx;
    logic [NUM_DIGITS-1:0]   disp_dp, disp_dp_nx;
    logic [4*NUM_DIGITS-1:0] pend_digits;
    logic [NUM_DIGITS-1:0]   pend_dp;
    logic                    pend_valid;

    logic [NUM_DIGITS-1:0]   supp;
    logic                    zero_run;
    logic [3:0]              bcd_nx;
    logic [NUM_DIGITS-1:0]   an_nx;
    logic                    dpn_nx;

    // Next-state logic: slot counter, digit index and scan phase.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        idx_nx   = digit_idx;
        if (!enable) begin
            state_nx = IDLE;
            cnt_nx   = '0;
            idx_nx   = '0;
        end else begin
            case (state)
                IDLE: begin
                    state_nx = BLANK;
                    cnt_nx   = '0;
                    idx_nx   = '0;
                end
                default: begin
                    if (cnt == CNT_LAST) begin
                        state_nx = BLANK;
                        cnt_nx   = '0;
                        idx_nx   = (digit_idx == IDX_LAST) ? '0 : digit_idx + 1'b1;
                    end else begin
                        cnt_nx   = cnt + 1'b1;
                        state_nx = (cnt_nx >= CNT_DRIVE) ? DRIVE : BLANK;
                    end
                end
            endcase
        end
        tick_nx = (state_nx != IDLE) && (idx_nx == IDX_LAST) && (cnt_nx == CNT_LAST);
    end

    // Display register next value: commit at the frame boundary, or right away while idle.
    always_comb begin
        disp_digits_nx = disp_digits;
        disp_dp_nx     = disp_dp;
        if (frame_tick && load) begin
            disp_digits_nx = digits_in;
            disp_dp_nx     = dp_in;
        end else if ((frame_tick || state == IDLE) && pend_valid) begin
            disp_digits_nx = pend_digits;
            disp_dp_nx     = pend_dp;
        end
    end

    // Output decode from next-cycle values so the registered outputs line up with the state.
    always_comb begin
        zero_run = 1'b1;
        supp     = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_run = zero_run && (disp_digits_nx[4*i +: 4] == 4'd0);
            supp[i]  = (LZ_BLANK != 0) && (i != 0) && zero_run;
        end
        bcd_nx = disp_digits_nx[{idx_nx, 2'b00} +: 4];
        an_nx  = '1;
        dpn_nx = 1'b1;
        if (state_nx == DRIVE && !supp[idx_nx]) begin
            an_nx[idx_nx] = 1'b0;
            dpn_nx        = ~disp_dp_nx[idx_nx];
        end
    end

    // Scan state, display data and registered outputs.
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the display and pending registers are reset too; a cleared display shows 0.
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            digit_idx   <= '0;
            frame_tick  <= 1'b0;
            bcd_out     <= 4'd0;
            an_n        <= '1;
            dp_n        <= 1'b1;
            disp_digits <= '0;
            disp_dp     <= '0;
            pend_digits <= '0;
            pend_dp     <= '0;
            pend_valid  <= 1'b0;
        end else begin
            state       <= state_nx;
            cnt         <= cnt_nx;
            digit_idx   <= idx_nx;
            frame_tick  <= tick_nx;
            bcd_out     <= bcd_nx;
            an_n        <= an_nx;
            dp_n        <= dpn_nx;
            disp_digits <= disp_digits_nx;
            disp_dp     <= disp_dp_nx;
            if (load) begin
                pend_digits <= digits_in;
                pend_dp     <= dp_in;
                // Data loaded on the frame_tick cycle is committed directly.
                pend_valid  <= !frame_tick;
            end else if ((frame_tick || state == IDLE) && pend_valid) begin
                pend_valid  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Self-checking bench for seven_seg_scan_driver with a short slot
// (REFRESH_DIV = 8, BLANK_CYCLES = 2) so whole frames are 32 cycles.
module tb_seven_seg_scan_driver;

    localparam int N = 4;
    localparam int R = 8;
    localparam int B = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        enable = 1'b0;
    logic        load = 1'b0;
    logic [15:0] digits_in = '0;
    logic [3:0]  dp_in = '0;
    logic [3:0]  bcd_out;
    logic [3:0]  an_n;
    logic        dp_n;
    logic [1:0]  digit_idx;
    logic        frame_tick;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    typedef struct {
        logic [3:0] an;
        logic [3:0] bcd;
        logic       dpn;
        logic       tick;
        logic [1:0] idx;
    } exp_t;

    exp_t sb[$];

    seven_seg_scan_driver #(
        .NUM_DIGITS  (N),
        .REFRESH_DIV (R),
        .BLANK_CYCLES(B),
        .LZ_BLANK    (1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .load      (load),
        .digits_in (digits_in),
        .dp_in     (dp_in),
        .bcd_out   (bcd_out),
        .an_n      (an_n),
        .dp_n      (dp_n),
        .digit_idx (digit_idx),
        .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    // Expected outputs for cycles c0..c1 of slot s showing the given digits.
    task automatic push_slot(input logic [15:0] dig, input logic [3:0] dp,
                             input int s, input int c0, input int c1);
        exp_t        e;
        logic [15:0] above;
        logic        sup;
        above = dig >> (4 * s);
        sup   = (s > 0) && (above == 16'h0000);
        for (int c = c0; c <= c1; c++) begin
            e.idx  = 2'(s);
            e.bcd  = above[3:0];
            e.an   = 4'hF;
            e.dpn  = 1'b1;
            if (c >= B && !sup) begin
                e.an[s] = 1'b0;
                e.dpn   = ~dp[s];
            end
            e.tick = (s == N - 1) && (c == R - 1);
            sb.push_back(e);
        end
    endtask

    task automatic push_frame(input logic [15:0] dig, input logic [3:0] dp);
        for (int s = 0; s < N; s++) push_slot(dig, dp, s, 0, R - 1);
    endtask

    // Scoreboard drain: pop one expectation per cycle and compare at the falling edge.
    task automatic sb_run(input int n);
        exp_t e;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            cyc++;
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL sb_empty cycle=%0d got=empty want=entry", cyc);
            end else begin
                e = sb.pop_front();
                if (an_n !== e.an || bcd_out !== e.bcd || dp_n !== e.dpn ||
                    frame_tick !== e.tick || digit_idx !== e.idx) begin
                    failures++;
                    $display("FAIL scan cycle=%0d got an_n=%b bcd=%0d dp_n=%b tick=%b idx=%0d want an_n=%b bcd=%0d dp_n=%b tick=%b idx=%0d",
                             cyc, an_n, bcd_out, dp_n, frame_tick, digit_idx,
                             e.an, e.bcd, e.dpn, e.tick, e.idx);
                end
            end
        end
    endtask

    task automatic idle_load(input logic [15:0] dig, input logic [3:0] dp);
        @(negedge clk);
        load      = 1'b1;
        digits_in = dig;
        dp_in     = dp;
        @(negedge clk);
        load = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (an_n !== 4'hF || dp_n !== 1'b1 || bcd_out !== 4'd0 ||
            frame_tick !== 1'b0 || digit_idx !== 2'd0) begin
            failures++;
            $display("FAIL reset got an_n=%b dp_n=%b bcd=%0d tick=%b idx=%0d want 1111 1 0 0 0",
                     an_n, dp_n, bcd_out, frame_tick, digit_idx);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic_scan();
        idle_load(16'h1234, 4'b0100);
        checks++;
        if (an_n !== 4'hF || frame_tick !== 1'b0) begin
            failures++;
            $display("FAIL idle_dark got an_n=%b tick=%b want 1111 0", an_n, frame_tick);
        end
        enable = 1'b1;
        push_frame(16'h1234, 4'b0100);
        sb_run(32);
    endtask

    task automatic test_tear_free();
        push_frame(16'h1234, 4'b0100);
        push_frame(16'h9876, 4'b0000);
        push_frame(16'h5555, 4'b0001);
        sb_run(11);
        load = 1'b1; digits_in = 16'h9876; dp_in = 4'b0000;
        sb_run(1);
        load = 1'b0;
        sb_run(20);
        sb_run(32);
        load = 1'b1; digits_in = 16'h5555; dp_in = 4'b0001;
        sb_run(1);
        load = 1'b0;
        sb_run(31);
    endtask

    task automatic test_leading_zero();
        @(negedge clk);
        enable = 1'b0;
        idle_load(16'h0050, 4'b0100);
        enable = 1'b1;
        push_frame(16'h0050, 4'b0100);
        push_frame(16'h0000, 4'b0001);
        sb_run(8);
        load = 1'b1; digits_in = 16'h0000; dp_in = 4'b0001;
        sb_run(1);
        load = 1'b0;
        sb_run(23);
        sb_run(32);
    endtask

    task automatic test_enable_drop();
        @(negedge clk);
        enable = 1'b0;
        idle_load(16'h1234, 4'b0100);
        enable = 1'b1;
        push_slot(16'h1234, 4'b0100, 0, 0, R - 1);
        push_slot(16'h1234, 4'b0100, 1, 0, R - 1);
        push_slot(16'h1234, 4'b0100, 2, 0, 3);
        sb_run(20);
        enable = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (an_n !== 4'hF || digit_idx !== 2'd0 || dp_n !== 1'b1 || frame_tick !== 1'b0) begin
                failures++;
                $display("FAIL enable_drop k=%0d got an_n=%b idx=%0d dp_n=%b tick=%b want 1111 0 1 0",
                         k, an_n, digit_idx, dp_n, frame_tick);
            end
        end
        enable = 1'b1;
        push_frame(16'h1234, 4'b0100);
        sb_run(32);
    endtask

    task automatic test_async_reset();
        push_slot(16'h1234, 4'b0100, 0, 0, 4);
        sb_run(5);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (an_n !== 4'hF || dp_n !== 1'b1 || bcd_out !== 4'd0 || frame_tick !== 1'b0) begin
            failures++;
            $display("FAIL async_reset got an_n=%b dp_n=%b bcd=%0d tick=%b want 1111 1 0 0",
                     an_n, dp_n, bcd_out, frame_tick);
        end
        @(negedge clk);
        rst_n = 1'b1;
        push_frame(16'h0000, 4'b0000);
        sb_run(32);
    endtask

    initial begin
        test_reset();
        test_basic_scan();
        test_tear_free();
        test_leading_zero();
        test_enable_drop();
        test_async_reset();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL sb_leftover got=%0d want=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
